// File: rtl/sc_spil_csctl.sv
// Chip-select sequencer for SPI Lite: setup/hold/gap timing around shift-engine words, with CS chaining.
// Optional range check on the requested CS index: define SC_SPIL_CSCTL_RANGE_CHK_EN.
module sc_spil_csctl #(
  parameter int unsigned NUM_OF_CS = 32,
  parameter int unsigned DLY_W     = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [4:0]       REQ_CS,
  input  logic             REQ_KEEP,
  input  logic             DESELECT,
  input  logic [DLY_W-1:0] SETUP_CYC,
  input  logic [DLY_W-1:0] HOLD_CYC,
  input  logic [DLY_W-1:0] GAP_CYC,
  output logic             XFER_START,
  input  logic             XFER_DONE,
  output logic [4:0]       CS_SEL,
  output logic             CSB,
  output logic             BUSY,
  output logic             ERR
);

  localparam int unsigned CS_W = 5;
  localparam logic [CS_W:0] CS_LIMIT = 6'(NUM_OF_CS);

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, CHAIN, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [DLY_W-1:0]  setup_q, setup_d;
  logic [DLY_W-1:0]  hold_q, hold_d;
  logic [DLY_W-1:0]  gap_q, gap_d;
  logic [CS_W-1:0]   cs_sel_q, cs_sel_d;
  logic [CS_W-1:0]   pend_cs_q, pend_cs_d;
  logic              pend_q, pend_d;
  logic              keep_q, keep_d;
  logic              csb_q, csb_d;
  logic              start_q, start_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              range_chk_c;
  logic              accept_c;
  logic              bad_cs_c;
  logic              launch_c;
  logic [CS_W-1:0]   launch_cs_c;
  logic [DLY_W-1:0]  launch_su_c;
  logic              hold_go_c;
  logic [DLY_W-1:0]  hold_val_c;

`ifdef SC_SPIL_CSCTL_RANGE_CHK_EN
  assign range_chk_c = 1'b1;
`else
  assign range_chk_c = 1'b0;
`endif

  assign accept_c = REQ_VALID & ready_q;
  assign bad_cs_c = range_chk_c & ({1'b0, REQ_CS} >= CS_LIMIT);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    setup_d     = setup_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    cs_sel_d    = cs_sel_q;
    pend_cs_d   = pend_cs_q;
    pend_d      = pend_q;
    keep_d      = keep_q;
    csb_d       = csb_q;
    start_d     = 1'b0;
    err_d       = 1'b0;
    launch_c    = 1'b0;
    launch_cs_c = REQ_CS;
    launch_su_c = SETUP_CYC;
    hold_go_c   = 1'b0;
    hold_val_c  = HOLD_CYC;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (bad_cs_c) begin
            err_d = 1'b1;
          end else begin
            launch_c = 1'b1;
            keep_d   = REQ_KEEP;
            hold_d   = HOLD_CYC;
            gap_d    = GAP_CYC;
          end
        end
      end
      SETUP: begin
        if (cnt_q == DLY_W'(1)) begin
          start_d = 1'b1;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      WAIT: begin
        if (XFER_DONE) begin
          if (keep_q) begin
            state_d = CHAIN;
          end else begin
            hold_go_c  = 1'b1;
            hold_val_c = hold_q;
          end
        end
      end
      CHAIN: begin
        if (accept_c) begin
          if (bad_cs_c) begin
            err_d = 1'b1;
          end else if (REQ_CS == cs_sel_q) begin
            start_d = 1'b1;
            keep_d  = REQ_KEEP;
            hold_d  = HOLD_CYC;
            gap_d   = GAP_CYC;
            state_d = WAIT;
          end else begin
            // Different slave: close this select, run the new one after the gap
            pend_d    = 1'b1;
            pend_cs_d = REQ_CS;
            keep_d    = REQ_KEEP;
            setup_d   = SETUP_CYC;
            hold_d    = HOLD_CYC;
            gap_d     = GAP_CYC;
            hold_go_c = 1'b1;
          end
        end else if (DESELECT) begin
          hold_d    = HOLD_CYC;
          gap_d     = GAP_CYC;
          hold_go_c = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == DLY_W'(1)) begin
          csb_d   = 1'b1;
          cnt_d   = gap_q;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          if (pend_q) begin
            pend_d      = 1'b0;
            launch_c    = 1'b1;
            launch_cs_c = pend_cs_q;
            launch_su_c = setup_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // CS_SEL loads only in the cycle CSB falls
    if (launch_c) begin
      cs_sel_d = launch_cs_c;
      csb_d    = 1'b0;
      if (launch_su_c == '0) begin
        start_d = 1'b1;
        state_d = WAIT;
      end else begin
        cnt_d   = launch_su_c;
        state_d = SETUP;
      end
    end

    if (hold_go_c) begin
      if (hold_val_c == '0) begin
        csb_d   = 1'b1;
        cnt_d   = gap_d;
        state_d = GAP;
      end else begin
        cnt_d   = hold_val_c;
        state_d = HOLD;
      end
    end

    ready_d = (state_d == IDLE) || (state_d == CHAIN);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      setup_q   <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      cs_sel_q  <= '0;
      pend_cs_q <= '0;
      pend_q    <= 1'b0;
      keep_q    <= 1'b0;
      csb_q     <= 1'b1;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      setup_q   <= setup_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      cs_sel_q  <= cs_sel_d;
      pend_cs_q <= pend_cs_d;
      pend_q    <= pend_d;
      keep_q    <= keep_d;
      csb_q     <= csb_d;
      start_q   <= start_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign REQ_READY  = ready_q;
  assign XFER_START = start_q;
  assign CS_SEL     = cs_sel_q;
  assign CSB        = csb_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;

endmodule

// File: doc/sc_spil_csctl.md
Name: sc_spil_csctl

Overview:
Chip-select sequencer for SPI Lite. Accepts transfer requests that name a target slave, and drives the CS select index and the active-low chip-select strobe into the chip-select decoder. Enforces programmable CS setup, hold and inter-transfer gap timing around each transfer. Hands transfers to the shift engine with a start/done handshake, and can keep CS asserted across chained words.

Parameters:
NUM_OF_CS, 32, number of physical chip selects (1..32)
DLY_W, 8, width of the setup/hold/gap cycle-count inputs

Ports:
CLK  input  1  clock
RSTN  input  1  reset, synchronous, active-low
REQ_VALID  input  1  transfer request valid
REQ_READY  output  1  request accepted when VALID&READY on a CLK edge
REQ_CS  input  5  target chip-select index
REQ_KEEP  input  1  keep CS asserted after this transfer (chain)
DESELECT  input  1  release a kept CS (single-cycle pulse)
SETUP_CYC  input  DLY_W  CS-low to transfer-start cycles
HOLD_CYC  input  DLY_W  transfer-done to CS-high cycles
GAP_CYC  input  DLY_W  minimum CS-high cycles between selects, minus 1
XFER_START  output  1  one-cycle pulse: shift engine begins a word
XFER_DONE  input  1  one-cycle pulse from shift engine: word complete
CS_SEL  output  5  index to chip-select decoder
CSB  output  1  active-low strobe to chip-select decoder
BUSY  output  1  high in any state other than IDLE
ERR  output  1  one-cycle pulse on a rejected request (optional feature only)

Behaviour:
- Reset: on CLK edge with RSTN=0, all outputs go to reset values: CSB=1, CS_SEL=0, XFER_START=0, REQ_READY=0, BUSY=0, ERR=0; state=IDLE, counters=0, pending flag=0.
- Reset mid-operation aborts immediately. No XFER_START and no CSB glitch low after reset.
- All outputs are registered.
- States: IDLE, SETUP, WAIT, CHAIN, HOLD, GAP.
- Timing inputs are latched at request accept (or at CHAIN exit for HOLD_CYC/GAP_CYC). Changes during a sequence are ignored.
- IDLE: REQ_READY=1.
  - On accept, latch REQ_CS and REQ_KEEP.
  - Next cycle (T0): CS_SEL=REQ_CS and CSB=0; go to SETUP.
- SETUP: XFER_START pulses in cycle T0+SETUP_CYC. SETUP_CYC=0 puts the pulse in T0. Then go to WAIT.
- WAIT: hold CSB=0 and ignore REQ_VALID (REQ_READY=0).
  - On XFER_DONE in cycle D: if the keep flag is set, go to CHAIN; else go to HOLD.
  - XFER_DONE is ignored in every state except WAIT.
- CHAIN: CSB stays 0 indefinitely; REQ_READY=1.
  - Accept with REQ_CS equal to the latched CS: XFER_START the following cycle (no setup delay), update the keep flag, go to WAIT.
  - Accept with a different REQ_CS: set the pending flag and latch the new request; go to HOLD.
  - DESELECT with no REQ_VALID: go to HOLD.
  - REQ_VALID and DESELECT in the same cycle: the request wins and DESELECT is ignored.
- HOLD: CSB=0 through cycle D+HOLD_CYC (or exit cycle+HOLD_CYC). CSB=1 in the next cycle; go to GAP.
- GAP: CSB=1 for GAP_CYC+1 cycles.
  - If pending: then load CS_SEL, CSB=0, clear pending, go to SETUP.
  - Otherwise go to IDLE. REQ_READY rises in the cycle IDLE is entered.
- CS_SEL changes only while CSB=1 or in the same cycle CSB falls, so the decoder never switches a live select.
- Counters are down-counters of DLY_W bits and do not wrap. The all-ones value gives the maximum delay of 2^DLY_W-1 extra cycles.
- XFER_START never overlaps a cycle with CSB=1.

Optional Feature:
SC_SPIL_CSCTL_RANGE_CHK_EN
- Defined: a request with REQ_CS >= NUM_OF_CS is accepted (handshake completes) but not executed. ERR pulses for one cycle after accept, CSB stays 1, and the state does not change. In CHAIN, a bad request is rejected the same way and the chain is kept.
- Not defined: ERR is tied 0. REQ_CS is used unchecked; out-of-range behaviour is owned by the decoder.

Test Plan:
- Single word, REQ_CS=3, SETUP=2, HOLD=1, GAP=0, keep=0 -> CS_SEL=3 at T0; XFER_START at T0+2; done at D gives CSB=1 at D+2; REQ_READY at D+3.
- SETUP=0, HOLD=0 -> XFER_START in the same cycle CSB falls; CSB high the cycle after XFER_DONE.
- Chain: three words to CS 5 with keep=1,1,0 -> CSB low continuously; start pulses 1 cycle after each accept in CHAIN; single CSB rise after last HOLD.
- Chain on CS 5, then request CS 9 -> HOLD, CSB high GAP_CYC+1 cycles, CS_SEL changes to 9 only while CSB=1, then setup and XFER_START.
- RSTN=0 asserted in WAIT with CSB=0 -> next edge CSB=1, BUSY=0, no XFER_START; subsequent XFER_DONE is ignored.
- With SC_SPIL_CSCTL_RANGE_CHK_EN, NUM_OF_CS=8, REQ_CS=12 -> ERR pulse, CSB stays 1, BUSY stays 0.
